// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizing constants and the 1-to-32 write demux helper.
// Rev 1.0
`default_nettype none
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = $clog2(NREGS);

  localparam int DEMUX_OUTS = NREGS;

  // One-hot decode of a register index; gating with the write strobe is left to the caller.
  function automatic logic [DEMUX_OUTS-1:0] demux_1t32(input logic [ADDR_W-1:0] addr);
    logic [DEMUX_OUTS-1:0] sel;
    sel       = '0;
    sel[addr] = 1'b1;
    return sel;
  endfunction
endpackage
`default_nettype wire

// File: rtl/mux_32t1_32.sv
// mux_32t1_32: 32-to-1 selector over the packed register array, one operand wide.
// Rev 1.0
`default_nettype none
module mux_32t1_32
  import regfile_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int WAYS  = NREGS
) (
  input  logic [WAYS-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]          sel,
  output logic [WIDTH-1:0]           data
);
  assign data = regs[sel];
endmodule
`default_nettype wire

// File: rtl/reg_read_port.sv
// reg_read_port: two-operand register file read port, latency 1, with write bypass and a snapshot output buffer.
// Rev 1.0
`default_nettype none
module reg_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [15:0]       stall_cnt
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             wr_sel;
  logic [DATA_W-1:0]            rs_mux, rt_mux, rs_next, rt_next;
  logic                         accept;

  assign wr_sel = wr_en ? NREGS'(demux_1t32(wr_addr)) : '0;

  // Index 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
    end
  end

  mux_32t1_32 #(.WIDTH(DATA_W), .WAYS(NREGS)) u_mux_rs (
    .regs (regs),
    .sel  (rs_addr),
    .data (rs_mux)
  );

  mux_32t1_32 #(.WIDTH(DATA_W), .WAYS(NREGS)) u_mux_rt (
    .regs (regs),
    .sel  (rt_addr),
    .data (rt_mux)
  );

  // Same-cycle write forwarding; index 0 is excluded so it always reads zero.
  assign rs_next = (wr_en && (wr_addr == rs_addr) && (rs_addr != '0)) ? wr_data : rs_mux;
  assign rt_next = (wr_en && (wr_addr == rt_addr) && (rt_addr != '0)) ? wr_data : rt_mux;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rs_data   <= '0;
      rt_data   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rs_data   <= rs_next;
      rt_data   <= rt_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (rsp_valid && !rsp_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_reg_read_port.sv
// tb_reg_read_port: scoreboard bench for reg_read_port (reference register model plus expected-response queue).
// Rev 1.0
`default_nettype none
module tb_reg_read_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rs_data, rt_data;
  logic [15:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mregs [32];
  logic [63:0] sb [$];
  logic [15:0] exp_stall = '0;

  reg_read_port #(.DATA_W(32), .NREGS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] ra, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return mregs[ra];
  endfunction

  // One clock: drive inputs, check/update model at the falling edge, then pass the rising edge.
  task automatic cycle(input logic rn, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [4:0] ra, input logic [4:0] rb, input logic rr);
    logic exp_ready;
    rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd;
    req_valid = rv; rs_addr = ra; rt_addr = rb; rsp_ready = rr;
    @(negedge clk);
    if (rn) begin
      exp_ready = (sb.size() == 0) || rr;
      chk("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      if (sb.size() != 0) begin
        chk("rs_data", 64'(rs_data), 64'(sb[0][63:32]));
        chk("rt_data", 64'(rt_data), 64'(sb[0][31:0]));
        if (rr) void'(sb.pop_front());
        else if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      end
      if (rv && exp_ready) sb.push_back({opnd(ra, we, wa, wd), opnd(rb, we, wa, wd)});
      if (we && wa != 5'd0) mregs[wa] = wd;
    end else begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      sb.delete();
      exp_stall = '0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    #1;
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd9, 5'd9, 1'b0);

    // Reset state and first read after a write
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

    // Write to r0 ignored
    cycle(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd5, 1'b1);

    // Same-cycle bypass, both operands on the same index
    cycle(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7, 1'b1);
    cycle(1'b1, 1'b1, 5'd0, 32'h0BADF00D, 1'b1, 5'd0, 5'd7, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

    // Snapshot hold under back-pressure while r3 is rewritten
    cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd0, 1'b0);
    chk("stall4", 64'(stall_cnt), 64'd4);
    chk("hold_rs", 64'(rs_data), 64'h11);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

    // Back-to-back full throughput with random writes
    for (int i = 0; i < 24; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);

    // Random mix of valid/ready
    for (int i = 0; i < 80; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 2) != 0));
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

    // Reset while a response is pending; a write during reset must be dropped
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 5'd5, 32'h55AA55AA, 1'b1, 5'd5, 5'd5, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers; address width log2(NREGS)=5.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port wr_en, input, 1, write strobe.
REQ-006 SHALL have port wr_addr, input, 5, write register index.
REQ-007 SHALL have port wr_data, input, DATA_W, write data.
REQ-008 SHALL have port req_valid, input, 1, read request present.
REQ-009 SHALL have port req_ready, output, 1, read request accepted this cycle when high with req_valid.
REQ-010 SHALL have port rs_addr, input, 5, first read index.
REQ-011 SHALL have port rt_addr, input, 5, second read index.
REQ-012 SHALL have port rsp_valid, output, 1, response holds valid data.
REQ-013 SHALL have port rsp_ready, input, 1, consumer takes response.
REQ-014 SHALL have port rs_data, output, DATA_W, data for rs_addr.
REQ-015 SHALL have port rt_data, output, DATA_W, data for rt_addr.
REQ-016 SHALL have port stall_cnt, output, 16, saturating count of cycles with rsp_valid=1 and rsp_ready=0.

Function
REQ-017 SHALL hold NREGS x DATA_W storage; a write with wr_en=1 updates storage at the rising edge.
REQ-018 SHALL ignore writes to index 0; reads of index 0 SHALL return 0.
REQ-019 SHALL drive req_ready = !rsp_valid || rsp_ready (one-entry output buffer, full throughput).
REQ-020 SHALL, on accept (req_valid && req_ready), register rs/rt data so rsp_valid=1 in the next cycle (latency 1).
REQ-021 SHALL bypass: if wr_en=1 and wr_addr equals a nonzero read index in the accept cycle, return wr_data for that operand.
REQ-022 SHALL, while rsp_valid=1 and rsp_ready=0, hold rs_data/rt_data stable even if the underlying register is written (snapshot semantics).
REQ-023 SHALL clear rsp_valid after a handshake (rsp_valid && rsp_ready) when no new request is accepted in that cycle; if accepted, load new data with rsp_valid remaining 1.
REQ-024 SHALL increment stall_cnt by 1 per stall cycle and saturate at 16'hFFFF.
REQ-025 SHALL treat rs_addr equal to rt_addr as legal; both outputs carry identical data.

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, clear all registers to 0, rsp_valid to 0, rs_data/rt_data to 0, stall_cnt to 0.
REQ-027 SHALL discard any pending or accepted request when reset is asserted mid-operation; wr_en during reset is ignored.
REQ-028 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-029 SHALL take DATA_W, NREGS, and the 5-bit address width from the shared package regfile_pkg, next to the existing demux constants.
REQ-030 SHALL build each read operand from one sub-module mux_32t1_32 (32-to-1, 32-bit), instantiated twice; the write side mirrors the existing 1-to-32 write demux.

Verification
REQ-031 SHALL verify: after reset, write r5=0xDEADBEEF, then read rs=5, rt=0 -> one cycle later rsp_valid=1, rs_data=0xDEADBEEF, rt_data=0.
REQ-032 SHALL verify: write r0=0x12345678, then read rs=0 -> rs_data=0.
REQ-033 SHALL verify: same-cycle write r7=0xA5A5A5A5 with read rs=7 -> rs_data=0xA5A5A5A5 (bypass).
REQ-034 SHALL verify: response for r3=0x11 held with rsp_ready=0 for 4 cycles while r3 is rewritten to 0x22 -> rs_data stays 0x11, req_ready=0, stall_cnt=4.
REQ-035 SHALL verify: back-to-back requests with rsp_ready=1 every cycle -> one response per cycle, in order, req_ready never drops.
REQ-036 SHALL verify: assert rst_n=0 while rsp_valid=1 -> next cycle rsp_valid=0, stall_cnt=0, reading r5 returns 0.
